vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//   Timing generator driving the pixel-side inputs of the display path: produces
//   pixel-enable tick, pixel coordinates x/y, video_on, hsync/vsync and a frame
//   tick from the system clock. Consumers (display mux, paddle/ball renderers,
//   game FSM) sample x/y/video_on; hsync/vsync go straight to the VGA connector.
// PARAMETERS
//   CLK_DIV    4    system clocks per pixel (100 MHz -> 25 MHz); legal >= 1
//   H_DISPLAY  640  visible pixels per line
//   H_FRONT    16   horizontal front porch (pixels)
//   H_SYNC     96   hsync pulse width (pixels)
//   H_BACK     48   horizontal back porch (pixels)
//   V_DISPLAY  480  visible lines per frame
//   V_FRONT    10   vertical front porch (lines)
//   V_SYNC     2    vsync pulse width (lines)
//   V_BACK     33   vertical back porch (lines)
//   SYNC_POL   0    active level of hsync/vsync (0 = active-low)
// PORTS
//   clk         in   1   system clock
//   reset       in   1   asynchronous reset, active-low
//   p_tick      out  1   pixel enable, one clk wide, every CLK_DIV clks
//   x           out  10  horizontal count, 0..H_TOTAL-1
//   y           out  10  vertical count, 0..V_TOTAL-1
//   video_on    out  1   high when x < H_DISPLAY and y < V_DISPLAY
//   hsync       out  1   horizontal sync, level per SYNC_POL
//   vsync       out  1   vertical sync, level per SYNC_POL
//   frame_tick  out  1   one clk pulse in the first cycle x=0,y=0 is presented
// BEHAVIOUR
// - H_TOTAL=H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
//   Both must be <= 1024 (10-bit counters); elaboration-time check, no runtime wrap.
// - All outputs registered; no combinational path from inputs to outputs.
// - Reset (async, reset=0): div_cnt=0, p_tick=0, x=H_TOTAL-1, y=V_TOTAL-1,
//   video_on=0, hsync=vsync=~SYNC_POL (inactive), frame_tick=0. Values are
//   mutually consistent, so no glitch on release. Reset mid-frame: same values
//   immediately, asynchronously; restart exactly as from power-up.
// - Prescaler: div_cnt counts 0..CLK_DIV-1, wraps; p_tick <= (div_cnt==CLK_DIV-1).
//   First p_tick high after the CLK_DIV-th rising edge following reset release.
//   CLK_DIV=1: p_tick high every cycle from the first edge on.
// - Counter advance on each edge sampling p_tick=1: x<=x+1; at x==H_TOTAL-1,
//   x<=0 and y<=y+1; at y==V_TOTAL-1 with x wrap, y<=0. Otherwise hold.
// - video_on, hsync, vsync, frame_tick computed from the NEXT x/y and
//   registered on the same edge, so they always match the presented x/y.
// - hsync active for H_DISPLAY+H_FRONT <= x < H_DISPLAY+H_FRONT+H_SYNC
//   (656..751); vsync active for V_DISPLAY+V_FRONT <= y < ...+V_SYNC (490..491).
// - frame_tick high for exactly one clk, when x/y transition to (0,0); first
//   frame_tick follows the first p_tick after reset (reset state wraps to 0,0).
// - Between p_ticks all of x/y/video_on/hsync/vsync hold; frame_tick low.
// TESTING
// - Hold reset=0 10 clks, release -> x=799,y=524,video_on=0,hsync=vsync=1,
//   p_tick=0 until 4th edge; edge 5 -> x=0,y=0,video_on=1, frame_tick=1 one clk.
// - Free run, CLK_DIV=4 -> p_tick exactly every 4 clks, one clk wide; x increments
//   once per p_tick; line period 3200 clks.
// - One line -> video_on high for 640 pixels (2560 clks); hsync=0 exactly for
//   x=656..751 (384 clks); x wraps 799->0 with y+1.
// - One frame -> vsync=0 for y=490..491 (1600 pixels); frame_tick period
//   1,680,000 clks; y wraps 524->0 together with x 799->0.
// - Assert reset at x=300,y=200 for 1 clk between edges -> outputs take reset
//   values without waiting for clk; resumes from power-up sequence.
// - CLK_DIV=1 build -> p_tick constantly 1 after first edge; frame_tick every
//   420,000 clks; hsync/vsync/video_on aligned with x/y each cycle.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable prescaler, x/y raster counters, video_on, hsync/vsync, frame tick.
// Latency: every output is registered; x/y and all decodes update on the clk edge that samples p_tick=1.
// Backpressure: none. Free-running source; consumers sample x/y/video_on whenever they need them.
module vga_sync_gen #(
    parameter int   CLK_DIV   = 4,
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Prescaler width; a divide-by-1 build still needs a 1-bit register.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] CNT_ONE = 10'd1;

    // Region bounds compared in 11 bits so a bound of exactly 1024 still works.
    localparam logic [10:0] H_DISP_B   = 11'(H_DISPLAY);
    localparam logic [10:0] V_DISP_B   = 11'(V_DISPLAY);
    localparam logic [10:0] H_SYNC_S_B = 11'(H_SYNC_START);
    localparam logic [10:0] H_SYNC_E_B = 11'(H_SYNC_END);
    localparam logic [10:0] V_SYNC_S_B = 11'(V_SYNC_START);
    localparam logic [10:0] V_SYNC_E_B = 11'(V_SYNC_END);

    localparam logic SYNC_IDLE = ~SYNC_POL;

    // ------------------------------------------------------------------
    // Elaboration-time sanity checks: counters are 10 bits wide and never
    // need a runtime overflow guard as long as these hold.
    // ------------------------------------------------------------------
    if (H_TOTAL > 1024) begin : g_h_total_check
        $error("vga_sync_gen: H_TOTAL exceeds the 10-bit x counter");
    end
    if (V_TOTAL > 1024) begin : g_v_total_check
        $error("vga_sync_gen: V_TOTAL exceeds the 10-bit y counter");
    end
    if (CLK_DIV < 1) begin : g_clk_div_check
        $error("vga_sync_gen: CLK_DIV must be at least 1");
    end

    // ------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;

    logic [9:0] x_next;
    logic [9:0] y_next;
    logic       video_next;
    logic       hsync_act_next;
    logic       vsync_act_next;
    logic       frame_next;

    assign div_wrap = (div_cnt == DIV_LAST);

    // Prescaler: p_tick is registered, one clk wide, once every CLK_DIV clks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            p_tick  <= div_wrap;
            div_cnt <= div_wrap ? '0 : (div_cnt + DIV_ONE);
        end
    end

    // Next raster position: advance only on a pixel tick, wrap line then frame.
    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == X_LAST) begin
                x_next = '0;
                y_next = (y == Y_LAST) ? '0 : (y + CNT_ONE);
            end else begin
                x_next = x + CNT_ONE;
            end
        end
    end

    // Region decode on the next position so registered flags line up with x/y.
    always_comb begin
        video_next     = ({1'b0, x_next} < H_DISP_B) && ({1'b0, y_next} < V_DISP_B);
        hsync_act_next = ({1'b0, x_next} >= H_SYNC_S_B) && ({1'b0, x_next} < H_SYNC_E_B);
        vsync_act_next = ({1'b0, y_next} >= V_SYNC_S_B) && ({1'b0, y_next} < V_SYNC_E_B);
        // Only a real advance into (0,0) counts; holding at (0,0) between ticks does not.
        frame_next     = p_tick && (x_next == '0) && (y_next == '0);
    end

    // Raster counters; reset parks at the last pixel so the first tick wraps to (0,0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= X_LAST;
            y <= Y_LAST;
        end else begin
            x <= x_next;
            y <= y_next;
        end
    end

    // Registered video/sync/frame flags, consistent with the reset raster position.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            video_on   <= 1'b0;
            hsync      <= SYNC_IDLE;
            vsync      <= SYNC_IDLE;
            frame_tick <= 1'b0;
        end else begin
            video_on   <= video_next;
            hsync      <= hsync_act_next ? SYNC_POL : SYNC_IDLE;
            vsync      <= vsync_act_next ? SYNC_POL : SYNC_IDLE;
            frame_tick <= frame_next;
        end
    end

endmodule
